// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue: in-order {pc, instruction} buffer between fetch and decode,
//              with a flush that discards every buffered entry.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 30,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [PC_W-1:0]              out_pc,
  output logic [5:0]                   out_opcode,
  output logic [15:0]                  out_imm16,
  output logic [25:0]                  out_addr26,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [DATA_W-1:0] instr_mem_d [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];
  logic [PC_W-1:0]   pc_mem_d    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic push;
  logic pop;

  // in_ready depends only on registered count, so a pop never frees a slot in the same cycle
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_instr  = instr_mem_q[rd_ptr_q];
  assign out_pc     = pc_mem_q[rd_ptr_q];
  assign out_opcode = out_instr[31:26];
  assign out_imm16  = out_instr[15:0];
  assign out_addr26 = out_instr[25:0];
  assign count      = count_q;

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = in_instr;
        pc_mem_d[wr_ptr_q]    = in_pc;
        // DEPTH is a power of two, so natural overflow wraps DEPTH-1 to 0
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue: directed stimulus for fetch_queue checked against a queue model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH  = 2;
  localparam int PC_W   = 30;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr  = '0;
  logic [PC_W-1:0]   in_pc     = '0;
  logic              flush     = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [5:0]        out_opcode;
  logic [15:0]       out_imm16;
  logic [25:0]       out_addr26;
  logic [CNT_W-1:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_opcode(out_opcode),
    .out_imm16 (out_imm16),
    .out_addr26(out_addr26),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain ordered list of {pc, instr}; storage is known-zero only until the first push after reset
  logic [PC_W+DATA_W-1:0] mq [$];
  bit                     zero_st = 1'b1;

  always @(posedge clk or posedge reset) begin : model
    bit m_push, m_pop;
    if (reset) begin
      mq.delete();
      zero_st = 1'b1;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop)  void'(mq.pop_front());
        if (m_push) begin
          mq.push_back({in_pc, in_instr});
          zero_st = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [DATA_W-1:0] ei;
    chk("count",     64'(count),     64'(mq.size()));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      ei = mq[0][DATA_W-1:0];
      chk("out_pc",     64'(out_pc),     64'(mq[0][PC_W+DATA_W-1:DATA_W]));
      chk("out_instr",  64'(out_instr),  64'(ei));
      chk("out_opcode", 64'(out_opcode), 64'(ei[31:26]));
      chk("out_imm16",  64'(out_imm16),  64'(ei[15:0]));
      chk("out_addr26", 64'(out_addr26), 64'(ei[25:0]));
    end else if (zero_st) begin
      chk("out_instr_rst", 64'(out_instr), 64'd0);
      chk("out_pc_rst",    64'(out_pc),    64'd0);
    end
  end

  // Called at a negedge: apply inputs, let one posedge happen, return at the next negedge
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // T1: reset mid-stream with one entry buffered
    drive(1'b1, 30'h20, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("t1_count_pre", 64'(count),  64'd1);
    chk("t1_pc_pre",    64'(out_pc), 64'h20);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t1_count",     64'(count),     64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_in_ready",  64'(in_ready),  64'd1);
    chk("t1_out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // T2: fill with decode stalled
    drive(1'b1, 30'h10, 32'h8C220004, 1'b0, 1'b0);
    drive(1'b1, 30'h11, 32'h00432020, 1'b0, 1'b0);
    chk("t2_count",    64'(count),     64'd2);
    chk("t2_in_ready", 64'(in_ready),  64'd0);
    chk("t2_instr",    64'(out_instr), 64'h8C220004);
    drive(1'b1, 30'h12, 32'h11111111, 1'b0, 1'b0);
    chk("t2_hold",     64'(out_instr), 64'h8C220004);
    chk("t2_count2",   64'(count),     64'd2);

    // T3: full with pop and push offered -> pop only
    drive(1'b1, 30'h12, 32'h11111111, 1'b1, 1'b0);
    chk("t3_count", 64'(count),  64'd1);
    chk("t3_pc",    64'(out_pc), 64'h11);
    drive(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_empty", 64'(count), 64'd0);

    // T4: streaming through wrapping pointers
    drive(1'b1, 30'd0, 32'hA000_0000, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 30'(i), 32'hA000_0000 | 32'(i), 1'b1, 1'b0);
      chk("t4_count", 64'(count),  64'd1);
      chk("t4_pc",    64'(out_pc), 64'(i));
    end
    drive(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_underflow", 64'(count), 64'd0);

    // T5: flush beats simultaneous push and pop
    drive(1'b1, 30'h30, 32'h0000_0030, 1'b0, 1'b0);
    drive(1'b1, 30'h31, 32'h0000_0031, 1'b0, 1'b0);
    drive(1'b1, 30'h32, 32'h0000_0032, 1'b1, 1'b1);
    chk("t5_count",     64'(count),     64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 30'h40, 32'h0000_0040, 1'b0, 1'b0);
    drive(1'b1, 30'h41, 32'h0000_0041, 1'b1, 1'b1);
    chk("t5_count_b",   64'(count),     64'd0);

    // T6: decoded fields of the head entry, one cycle after push
    drive(1'b1, 30'h50, 32'h1000FFFE, 1'b0, 1'b0);
    chk("t6_valid",  64'(out_valid),  64'd1);
    chk("t6_pc",     64'(out_pc),     64'h50);
    chk("t6_opcode", 64'(out_opcode), 64'h04);
    chk("t6_imm16",  64'(out_imm16),  64'hFFFE);
    chk("t6_addr26", 64'(out_addr26), 64'h000FFFE);

    drive(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 30'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
